data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 5, clock cycles from request acceptance to access completion; legal range 1..15.
REQ-002 clock  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 read  input  1  word-read request from the cache controller.
REQ-005 write  input  1  word-write request from the cache controller.
REQ-006 address  input  6  word address, equal to byte address[7:2].
REQ-007 writedata  input  32  word to store.
REQ-008 readdata  output  32  registered word returned by a read.
REQ-009 busywait  output  1  high while a request is pending or in progress.

Function
REQ-010 Storage SHALL be 256 bytes organised as 64 words of 32 bits, little-endian: word w, bits [8k+7:8k], maps to byte 4w+k.
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 The FSM SHALL have a 4-bit down-counter cnt.
REQ-013 In IDLE, at a rising edge with read or write high:
- latch address, op and writedata;
- load cnt with LATENCY-1;
- enter BUSY.
REQ-014 In IDLE, if read and write are both high, the block SHALL perform a read and SHALL NOT write.
REQ-015 In BUSY, at each rising edge with cnt!=0, cnt SHALL decrement and the state SHALL remain BUSY.
REQ-016 In BUSY, at the rising edge with cnt==0, the block SHALL perform the latched access and enter DONE.
- Read: readdata <= mem[latched address].
- Write: mem[latched address] <= latched writedata, and readdata is unchanged.
REQ-017 The access SHALL complete exactly LATENCY rising edges after the acceptance edge.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-019 Requests present during DONE SHALL be ignored, so a request still asserted while the controller leaves its wait state is not re-executed.
REQ-020 busywait SHALL be combinational: busywait = (state==BUSY) or (state==IDLE and (read or write)).
REQ-021 busywait SHALL therefore rise in the same cycle a request appears, and fall after the completion edge.
REQ-022 busywait SHALL be low throughout DONE.
REQ-023 Once a request is accepted it is committed. Deasserting read/write or changing address/writedata during BUSY SHALL NOT alter or abort the access.
REQ-024 readdata SHALL hold its last value until the next completed read.
REQ-025 When LATENCY=1, the access SHALL complete at the edge after acceptance, and busywait SHALL be high for exactly one cycle.

Reset
REQ-026 While reset is high, regardless of clock:
- state = IDLE;
- cnt = 0;
- readdata = 32'h0;
- all 64 words = 32'h0.
REQ-027 busywait SHALL be low while reset is high.
REQ-028 Reset asserted during BUSY SHALL abort the access: no write is performed and readdata stays 0.
REQ-029 After reset deasserts, the first rising edge with a request SHALL be treated as an acceptance edge.

Verification
REQ-030 Write then read, LATENCY=5:
- write=1, address=6'h05, writedata=32'hDEADBEEF; hold until busywait falls;
- then read=1, address=6'h05;
- required: busywait high for 5 cycles each; readdata=32'hDEADBEEF after the 5th edge.
REQ-031 Reset-cleared read: after reset, read address 6'h3F -> readdata=32'h0 after 5 edges.
REQ-032 Byte order: write 32'h44332211 to address 6'h00, then read it back:
- readdata=32'h44332211;
- internal byte 0 = 8'h11 and byte 3 = 8'h44.
REQ-033 Held request: read=1 kept asserted for two cycles beyond busywait falling.
- Exactly one access is performed.
- busywait is low in DONE.
- A new access is accepted only at the IDLE edge.
REQ-034 Mid-operation events:
- Reset during BUSY of a write of 32'hCAFEF00D to 6'h10 -> a later read of 6'h10 returns 32'h0.
- A request changed mid-BUSY (address 6'h01 -> 6'h02) -> the access uses 6'h01.
REQ-035 Simultaneous read=1 and write=1 to 6'h07 holding 32'h12345678, writedata=32'hFFFFFFFF -> readdata=32'h12345678, and memory is unchanged.

Source files
------------

// File: rtl/data_memory.sv
// 64x32 little-endian word memory behind a fixed LATENCY-cycle access pipeline.
// Access completes LATENCY edges after acceptance; busywait stalls the requester until then.
module data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [5:0]  lat_addr;
    logic        lat_wr;
    logic [31:0] lat_wdata;
    logic [7:0]  mem [0:255];
    logic        accept;
    logic        complete;

    assign accept   = (state == IDLE) && (read || write);
    assign complete = (state == BUSY) && (cnt == 4'd0);

    // Gated by reset so a request held across reset never shows as busy.
    assign busywait = !reset && ((state == BUSY) || accept);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (read || write) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A simultaneous read and write is latched as a read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            lat_addr  <= 6'd0;
            lat_wr    <= 1'b0;
            lat_wdata <= 32'h0;
        end else if (accept) begin
            cnt       <= CNT_LOAD;
            lat_addr  <= address;
            lat_wr    <= write && !read;
            lat_wdata <= writedata;
        end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata <= 32'h0;
            for (int i = 0; i < 256; i++) begin
                mem[8'(i)] <= 8'h0;
            end
        end else if (complete) begin
            if (lat_wr) begin
                mem[{lat_addr, 2'd0}] <= lat_wdata[7:0];
                mem[{lat_addr, 2'd1}] <= lat_wdata[15:8];
                mem[{lat_addr, 2'd2}] <= lat_wdata[23:16];
                mem[{lat_addr, 2'd3}] <= lat_wdata[31:24];
            end else begin
                readdata <= {mem[{lat_addr, 2'd3}], mem[{lat_addr, 2'd2}],
                             mem[{lat_addr, 2'd1}], mem[{lat_addr, 2'd0}]};
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, hand-written corner sequences and
// randomized traffic checked against a word-array reference model.
`timescale 1ns/1ps
module tb_data_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        read, write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;

    logic        r1, w1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [31:0] rd1;
    logic        bw1;

    data_memory #(.LATENCY(5)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata),
        .readdata(readdata), .busywait(busywait)
    );

    data_memory #(.LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .read(r1), .write(w1),
        .address(a1), .writedata(d1),
        .readdata(rd1), .busywait(bw1)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] mref [64];
    logic [31:0] rref;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mref[i] = 32'h0;
        rref = 32'h0;
    endtask

    // Entered just after a rising edge with the DUT idle; returns likewise.
    task automatic run_req(input logic rd, input logic wr, input logic [5:0] a,
                           input logic [31:0] d, input logic chg);
        int n;
        read = rd; write = wr; address = a; writedata = d;
        #1;
        check("bw_rise", {31'b0, busywait}, 32'd1);
        @(posedge clock); #1;
        if (chg) begin
            address = a + 6'd1; writedata = ~d; read = 1'b0; write = 1'b0;
        end
        n = 0;
        @(negedge clock);
        while (busywait && n < 40) begin
            n++;
            @(negedge clock);
        end
        read = 1'b0; write = 1'b0;
        check("busy_len", n, 32'd5);
        if (rd) rref = mref[a];
        else if (wr) mref[a] = d;
        check("readdata", readdata, rref);
        @(posedge clock); #1;
    endtask

    task automatic run1(input logic rd, input logic wr, input logic [5:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
        int n;
        r1 = rd; w1 = wr; a1 = a; d1 = d;
        #1;
        check("lat1_bw_rise", {31'b0, bw1}, 32'd1);
        @(posedge clock); #1;
        n = 0;
        @(negedge clock);
        while (bw1 && n < 40) begin
            n++;
            @(negedge clock);
        end
        r1 = 1'b0; w1 = 1'b0;
        check("lat1_busy_len", n, 32'd1);
        check("lat1_readdata", rd1, exp);
        @(posedge clock); #1;
    endtask

    initial begin
        int n;
        logic [1:0] op;

        tbl[0] = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 6'h00, 32'h44332211, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b0, 6'h00, 32'h0,        32'h44332211};
        tbl[5] = '{1'b0, 1'b1, 6'h07, 32'h12345678, 32'h44332211};
        tbl[6] = '{1'b1, 1'b1, 6'h07, 32'hFFFFFFFF, 32'h12345678};
        tbl[7] = '{1'b1, 1'b0, 6'h07, 32'h0,        32'h12345678};

        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
        model_reset();

        // Reset with a request held: busywait must stay low.
        #2 reset = 1'b1;
        read = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_readdata", readdata, 32'h0);
        check("rst_busywait", {31'b0, busywait}, 32'd0);
        read = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) begin
            run_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0);
            check($sformatf("vec%0d", i), readdata, tbl[i].exp);
        end
        check("byte0", {24'b0, dut.mem[0]}, 32'h11);
        check("byte3", {24'b0, dut.mem[3]}, 32'h44);
        check("rdwr_unchanged", {dut.mem[31], dut.mem[30], dut.mem[29], dut.mem[28]}, 32'h12345678);

        // Held read: DONE must not re-accept; IDLE sees it, deassert before the next edge.
        read = 1'b1; address = 6'h05;
        @(posedge clock); #1;
        n = 0;
        @(negedge clock);
        while (busywait && n < 40) begin
            n++;
            @(negedge clock);
        end
        check("held_len", n, 32'd5);
        check("held_data", readdata, 32'hDEADBEEF);
        @(posedge clock); #1;
        check("held_idle_bw", {31'b0, busywait}, 32'd1);
        @(negedge clock);
        read = 1'b0;
        #1;
        check("held_no_reexec", {31'b0, busywait}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("held_quiet", {31'b0, busywait}, 32'd0);
        end
        @(posedge clock); #1;
        rref = 32'hDEADBEEF;

        // Address and data change mid-BUSY: access keeps the latched values.
        run_req(1'b0, 1'b1, 6'h01, 32'hA1A1A1A1, 1'b0);
        run_req(1'b0, 1'b1, 6'h02, 32'hB2B2B2B2, 1'b0);
        run_req(1'b1, 1'b0, 6'h01, 32'h0, 1'b1);
        check("chg_addr", readdata, 32'hA1A1A1A1);
        run_req(1'b0, 1'b1, 6'h03, 32'h0F0F0F0F, 1'b1);
        run_req(1'b1, 1'b0, 6'h04, 32'h0, 1'b0);
        check("chg_wr_target", readdata, 32'h0);
        run_req(1'b1, 1'b0, 6'h03, 32'h0, 1'b0);
        check("chg_wr_data", readdata, 32'h0F0F0F0F);

        // Reset in the middle of a write aborts it.
        write = 1'b1; address = 6'h10; writedata = 32'hCAFEF00D;
        @(posedge clock); #1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1; write = 1'b0; read = 1'b1;
        #1;
        check("mid_rst_bw", {31'b0, busywait}, 32'd0);
        check("mid_rst_rd", readdata, 32'h0);
        @(negedge clock);
        read = 1'b0; reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        run_req(1'b1, 1'b0, 6'h10, 32'h0, 1'b0);
        check("abort_write", readdata, 32'h0);

        // LATENCY=1 instance.
        run1(1'b0, 1'b1, 6'h2A, 32'h0BADCAFE, 32'h0);
        run1(1'b1, 1'b0, 6'h2A, 32'h0, 32'h0BADCAFE);
        run1(1'b1, 1'b1, 6'h2A, 32'h11111111, 32'h0BADCAFE);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 2));
            run_req(op != 2'd1, op != 2'd0, 6'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
